xz_capture_buf: RTL and testbench



---
 rtl/xz_capture_buf.sv | 145 ++++++++++++++
 tb/tb_xz_capture_buf.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/xz_capture_buf.sv
// Two-entry capture FIFO for a 4-state link: flags words carrying X/Z, counts them and derives a clean enable.
// Optional build macro XZ_REPLACE_EN: unknown bits are patched from the last fully-known pushed word.
module xz_capture_buf #(
    parameter int DW   = 4,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_xz,
    input  logic            out_ready,
    output logic            en,
    output logic [CNTW-1:0] xz_cnt,
    output logic            in_valid_xz
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     head_q, head_d, tail_q, tail_d;
    logic              head_xz_q, head_xz_d, tail_xz_q, tail_xz_d;
    logic              en_q, en_d;
    logic              in_valid_xz_q, in_valid_xz_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              push, pop, xz_flag, valid_unknown, bit0_known;
    logic [DW-1:0]     cap_data;
`ifdef XZ_REPLACE_EN
    logic [DW-1:0]     ref_q, ref_d;
`endif

    always_comb begin
        // Case-equality keeps an X/Z in_valid from ever being taken as a push.
        push          = (in_valid === 1'b1) && (state_q != TWO);
        pop           = (state_q != EMPTY) && out_ready;
        valid_unknown = (in_valid !== 1'b0) && (in_valid !== 1'b1);
        xz_flag       = ((^in_data) === 1'bx);
        bit0_known    = (head_q[0] === 1'b0) || (head_q[0] === 1'b1);

        cap_data = in_data;
`ifdef XZ_REPLACE_EN
        for (int i = 0; i < DW; i++) begin
            if ((in_data[i] !== 1'b0) && (in_data[i] !== 1'b1)) begin
                cap_data[i] = ref_q[i];
            end
        end
        ref_d = ref_q;
        if (push && !xz_flag) begin
            ref_d = in_data;
        end
`endif

        state_d   = state_q;
        head_d    = head_q;
        head_xz_d = head_xz_q;
        tail_d    = tail_q;
        tail_xz_d = tail_xz_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d    = cap_data;
                    head_xz_d = xz_flag;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d    = cap_data;
                    head_xz_d = xz_flag;
                end else if (push) begin
                    tail_d    = cap_data;
                    tail_xz_d = xz_flag;
                    state_d   = TWO;
                end else if (pop) begin
                    state_d   = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_d    = tail_q;
                    head_xz_d = tail_xz_q;
                    state_d   = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        // An unknown bit 0 leaves the enable where it was so it never picks up X.
        en_d = en_q;
        if (pop && bit0_known) begin
            en_d = head_q[0];
        end

        cnt_d = cnt_q;
        if (push && xz_flag && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        in_valid_xz_d = in_valid_xz_q | valid_unknown;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= EMPTY;
            head_q        <= '0;
            head_xz_q     <= 1'b0;
            tail_q        <= '0;
            tail_xz_q     <= 1'b0;
            en_q          <= 1'b0;
            cnt_q         <= '0;
            in_valid_xz_q <= 1'b0;
`ifdef XZ_REPLACE_EN
            ref_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            head_xz_q     <= head_xz_d;
            tail_q        <= tail_d;
            tail_xz_q     <= tail_xz_d;
            en_q          <= en_d;
            cnt_q         <= cnt_d;
            in_valid_xz_q <= in_valid_xz_d;
`ifdef XZ_REPLACE_EN
            ref_q         <= ref_d;
`endif
        end
    end

    assign in_ready    = (state_q != TWO);
    assign out_valid   = (state_q != EMPTY);
    assign out_data    = head_q;
    assign out_xz      = head_xz_q;
    assign en          = en_q;
    assign xz_cnt      = cnt_q;
    assign in_valid_xz = in_valid_xz_q;

endmodule

// File: tb/tb_xz_capture_buf.sv
// Randomized and directed bench for xz_capture_buf against a queue-based reference model.
module tb_xz_capture_buf;

    localparam int DW   = 4;
    localparam int CNTW = 2;
    localparam int CMAX = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_xz;
    logic            out_ready;
    logic            en;
    logic [CNTW-1:0] xz_cnt;
    logic            in_valid_xz;

    int total = 0;
    int bad   = 0;

    xz_capture_buf #(.DW(DW), .CNTW(CNTW)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_xz(out_xz), .out_ready(out_ready), .en(en), .xz_cnt(xz_cnt),
        .in_valid_xz(in_valid_xz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          x;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] m_last_d;
    logic          m_last_x;
    logic          m_en;
    logic          m_vxz;
    int            m_cnt;
    logic [DW-1:0] m_ref;

    function automatic void model_reset();
        q.delete();
        m_last_d = '0;
        m_last_x = 1'b0;
        m_en     = 1'b0;
        m_vxz    = 1'b0;
        m_cnt    = 0;
        m_ref    = '0;
    endfunction

    function automatic logic [DW-1:0] exp_data();
        return (q.size() > 0) ? q[0].d : m_last_d;
    endfunction

    function automatic logic exp_xz();
        return (q.size() > 0) ? q[0].x : m_last_x;
    endfunction

    // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
        logic          do_pop, do_push, flag;
        logic [DW-1:0] w;
        ent_t          e;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        do_pop  = (q.size() > 0) && r;
        do_push = (v === 1'b1) && (q.size() < 2);
        if ($isunknown(v)) m_vxz = 1'b1;
        flag = $isunknown(d);
        w    = d;
`ifdef XZ_REPLACE_EN
        for (int i = 0; i < DW; i++) if ($isunknown(d[i])) w[i] = m_ref[i];
`endif
        if (do_push) begin
            if (!flag) m_ref = d;
            if (flag && m_cnt < CMAX) m_cnt++;
        end
        if (do_pop) begin
            e = q.pop_front();
            m_last_d = e.d;
            m_last_x = e.x;
            if (!$isunknown(e.d[0])) m_en = e.d[0];
        end
        if (do_push) q.push_back('{w, flag});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_data = 4'bxxxx; out_ready = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        total++; if (out_data !== 4'd0) begin bad++; $display("FAIL rst_out_data got=%b want=0000", out_data); end
        total++; if (xz_cnt !== 2'd0) begin bad++; $display("FAIL rst_xz_cnt got=%0d want=0", xz_cnt); end
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 4'bxxxx, 1'b0);
        cyc(1'b0, 4'bxxxx, 1'b0);
        total++; if ({out_valid, in_ready, en, out_xz, in_valid_xz} !== 5'b01000) begin
            bad++; $display("FAIL idle_ctrl got=%b want=01000", {out_valid, in_ready, en, out_xz, in_valid_xz}); end
        total++; if (out_data !== 4'd0 || xz_cnt !== 2'd0) begin
            bad++; $display("FAIL idle_data got=%b/%0d want=0000/0", out_data, xz_cnt); end
    endtask

    task automatic test_basic();
        cyc(1'b1, 4'd3, 1'b1);
        total++; if (out_valid !== 1'b1 || out_data !== 4'd3 || out_xz !== 1'b0) begin
            bad++; $display("FAIL basic_head got=%b/%b/%b want=1/0011/0", out_valid, out_data, out_xz); end
        total++; if (en !== 1'b0) begin bad++; $display("FAIL basic_en_early got=%b want=0", en); end
        cyc(1'b0, 4'd0, 1'b1);
        total++; if (en !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_en got=%b/%b want=1/0", en, out_valid); end
        total++; if (out_data !== 4'd3) begin bad++; $display("FAIL basic_hold got=%b want=0011", out_data); end
    endtask

    task automatic test_xz_word();
        cyc(1'b1, 4'b1x0z, 1'b0);
        total++; if (out_xz !== exp_xz() || xz_cnt !== m_cnt[CNTW-1:0]) begin
            bad++; $display("FAIL xz_flag got=%b/%0d want=%b/%0d", out_xz, xz_cnt, exp_xz(), m_cnt); end
        total++; if (out_data !== exp_data()) begin
            bad++; $display("FAIL xz_data got=%b want=%b", out_data, exp_data()); end
`ifdef XZ_REPLACE_EN
        total++; if ($isunknown(out_data)) begin bad++; $display("FAIL xz_replace got=%b want=known", out_data); end
`endif
        cyc(1'b0, 4'd0, 1'b1);
        total++; if (en !== m_en || $isunknown(en)) begin
            bad++; $display("FAIL xz_en got=%b want=%b", en, m_en); end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 4'd5, 1'b0);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b want=1", in_ready); end
        cyc(1'b1, 4'd6, 1'b0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b want=0", in_ready); end
        cyc(1'b1, 4'd7, 1'b0);
        total++; if (in_ready !== 1'b0 || out_data !== 4'd5) begin
            bad++; $display("FAIL b2b_hold got=%b/%0d want=0/5", in_ready, out_data); end
        cyc(1'b0, 4'd0, 1'b1);
        total++; if (out_data !== 4'd6 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            bad++; $display("FAIL b2b_pop1 got=%0d/%b/%b want=6/1/1", out_data, in_ready, out_valid); end
        total++; if (en !== 1'b1) begin bad++; $display("FAIL b2b_en1 got=%b want=1", en); end
        cyc(1'b0, 4'd0, 1'b1);
        total++; if (out_valid !== 1'b0 || out_data !== 4'd6 || en !== 1'b0) begin
            bad++; $display("FAIL b2b_pop2 got=%b/%0d/%b want=0/6/0", out_valid, out_data, en); end
    endtask

    task automatic test_in_valid_xz();
        cyc(1'bx, 4'd9, 1'b0);
        total++; if (out_valid !== (q.size() > 0) || in_valid_xz !== m_vxz) begin
            bad++; $display("FAIL vxz_set got=%b/%b want=%b/%b", out_valid, in_valid_xz, q.size() > 0, m_vxz); end
        cyc(1'b0, 4'd0, 1'b0);
        cyc(1'b1, 4'd2, 1'b0);
        total++; if (in_valid_xz !== m_vxz || out_data !== 4'd2) begin
            bad++; $display("FAIL vxz_hold got=%b/%0d want=%b/2", in_valid_xz, out_data, m_vxz); end
        #2 rst = 1'b1;
        #1;
        total++; if ({out_valid, in_ready, in_valid_xz, en, out_xz} !== 5'b01000 || out_data !== 4'd0 || xz_cnt !== 2'd0) begin
            bad++; $display("FAIL mid_reset got=%b/%b/%0d want=01000/0000/0",
                            {out_valid, in_ready, in_valid_xz, en, out_xz}, out_data, xz_cnt); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_cnt_sat();
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 4'b01z1, 1'b1);
            total++; if (xz_cnt !== m_cnt[CNTW-1:0] || m_cnt > CMAX) begin
                bad++; $display("FAIL cnt_step%0d got=%0d want=%0d", k, xz_cnt, m_cnt); end
        end
    endtask

    task automatic test_random();
        logic          v, r;
        logic [DW-1:0] d;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 19) == 0) v = 1'bx;
            d = DW'($urandom);
            for (int i = 0; i < DW; i++) if ($urandom_range(0, 9) == 0) d[i] = ($urandom_range(0, 1) != 0) ? 1'bx : 1'bz;
            r = ($urandom_range(0, 2) != 0);
            cyc(v, d, r);
            total++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || out_data !== exp_data() ||
                out_xz !== exp_xz() || en !== m_en || xz_cnt !== m_cnt[CNTW-1:0] || in_valid_xz !== m_vxz) begin
                bad++;
                $display("FAIL rand%0d got v=%b r=%b d=%b x=%b en=%b c=%0d vx=%b want v=%b r=%b d=%b x=%b en=%b c=%0d vx=%b",
                         n, out_valid, in_ready, out_data, out_xz, en, xz_cnt, in_valid_xz,
                         q.size() > 0, q.size() < 2, exp_data(), exp_xz(), m_en, m_cnt, m_vxz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_xz_word();
        test_back_to_back();
        test_in_valid_xz();
        test_cnt_sat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
